// File: rtl/popcount_seq_if.sv
// Handshake and result bundle for popcount_seq; the block takes the slave
// modport, a driver or bench takes the master modport.
interface popcount_seq_if #(
    parameter int WORDLEN = 32,
    parameter int ACCLEN  = 16
);
    localparam int CW = $clog2(WORDLEN + 1);

    logic [WORDLEN-1:0] word_i;
    logic               valid_i;
    logic               ready_o;
    logic               accum_i;
    logic               clear_i;
    logic [CW-1:0]      count_o;
    logic [ACCLEN-1:0]  total_o;
    logic               valid_o;
    logic               sat_o;
    logic [1:0]         state_o;

    modport slave (
        input  word_i, valid_i, accum_i, clear_i,
        output ready_o, count_o, total_o, valid_o, sat_o, state_o
    );

    modport master (
        output word_i, valid_i, accum_i, clear_i,
        input  ready_o, count_o, total_o, valid_o, sat_o, state_o
    );
endinterface

// File: rtl/popcount_seq.sv
// Sequential population counter: counts CHUNK bits per cycle of a WORDLEN-bit
// word and keeps a saturating running total across words.
module popcount_seq #(
    parameter int WORDLEN = 32,
    parameter int CHUNK   = 8,
    parameter int ACCLEN  = 16
) (
    input  logic          clk_i,
    input  logic          rst_i,
    popcount_seq_if.slave bus
);
    localparam int NCH = WORDLEN / CHUNK;
    localparam int CW  = $clog2(WORDLEN + 1);
    localparam int IW  = (NCH > 1) ? $clog2(NCH) : 1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_COUNT = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_state_nx;
    logic [WORDLEN-1:0] r_word_sr;
    logic               r_accum;
    logic [CW-1:0]      r_partial;
    logic [IW-1:0]      r_idx;
    logic [CW-1:0]      r_count;
    logic [ACCLEN-1:0]  r_total;
    logic               r_sat;

    logic               w_ready;
    logic               w_fire;
    logic               w_last;
    logic               w_complete;
    logic [CW-1:0]      w_chunk_pop;
    logic [CW-1:0]      w_final;
    logic [ACCLEN-1:0]  w_base_total;
    logic               w_base_sat;
    logic [ACCLEN:0]    w_sum;
    logic [ACCLEN-1:0]  w_total_nx;
    logic               w_sat_nx;

    // Handshake: a word transfers on any rising edge where valid_i && ready_o;
    // ready_o depends on state only, so valid_i never loops back into it.
    assign w_ready    = (r_state != S_COUNT);
    assign w_fire     = bus.valid_i && w_ready;
    assign w_last     = (r_idx == IW'(NCH - 1));
    assign w_complete = (r_state == S_COUNT) && w_last;
    assign w_final    = r_partial + w_chunk_pop;

    always_comb begin
        w_chunk_pop = '0;
        for (int i = 0; i < CHUNK; i++) begin
            w_chunk_pop = w_chunk_pop + CW'(r_word_sr[i]);
        end
    end

    // Clear is folded into the base value so that it takes effect before a
    // completion landing in the same cycle.
    always_comb begin
        w_base_total = bus.clear_i ? '0 : r_total;
        w_base_sat   = bus.clear_i ? 1'b0 : r_sat;
        w_sum        = {1'b0, w_base_total} + {1'b0, ACCLEN'(w_final)};
        w_total_nx   = w_base_total;
        w_sat_nx     = w_base_sat;
        if (w_complete) begin
            if (!r_accum) begin
                w_total_nx = ACCLEN'(w_final);
                w_sat_nx   = 1'b0;
            end else if (w_sum[ACCLEN]) begin
                w_total_nx = '1;
                w_sat_nx   = 1'b1;
            end else begin
                w_total_nx = w_sum[ACCLEN-1:0];
            end
        end
    end

    always_comb begin
        w_state_nx = r_state;
        case (r_state)
            S_IDLE:  if (w_fire) w_state_nx = S_COUNT;
            S_COUNT: if (w_last) w_state_nx = S_DONE;
            S_DONE:  w_state_nx = w_fire ? S_COUNT : S_IDLE;
            default: w_state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nx;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_word_sr <= '0;
            r_accum   <= 1'b0;
            r_partial <= '0;
            r_idx     <= '0;
            r_count   <= '0;
            r_total   <= '0;
            r_sat     <= 1'b0;
        end else begin
            r_total <= w_total_nx;
            r_sat   <= w_sat_nx;
            if (w_fire) begin
                r_word_sr <= bus.word_i;
                r_accum   <= bus.accum_i;
                r_partial <= '0;
                r_idx     <= '0;
            end else if (r_state == S_COUNT) begin
                r_partial <= w_final;
                r_word_sr <= r_word_sr >> CHUNK;
                r_idx     <= r_idx + 1'b1;
                if (w_last) begin
                    r_count <= w_final;
                end
            end
        end
    end

    assign bus.ready_o = w_ready;
    assign bus.valid_o = (r_state == S_DONE);
    assign bus.count_o = r_count;
    assign bus.total_o = r_total;
    assign bus.sat_o   = r_sat;
    assign bus.state_o = r_state;
endmodule

// File: doc/popcount_seq.md
# popcount_seq

Multi-cycle, parametrised population counter that accepts a WORDLEN-bit word over a valid/ready handshake. It counts set bits CHUNK bits per cycle and reports each word's count with a one-cycle valid strobe. It also keeps a saturating running total across words in accumulate mode. It is the sequential successor to the single-cycle bit counter, used where wide words or many words must be tallied without a wide combinational adder tree.

## Interface
- WORDLEN, 32, input word width in bits; must be a multiple of CHUNK.
- CHUNK, 8, bits counted per cycle; 1 ≤ CHUNK ≤ WORDLEN.
- ACCLEN, 16, running-total width; must be ≥ $clog2(WORDLEN+1).
- clk_i  input  1  single clock; all state changes on the rising edge.
- rst_i  input  1  synchronous, active-high reset.
- word_i  input  WORDLEN  word to count; sampled only on handshake.
- valid_i  input  1  word_i and accum_i are valid.
- ready_o  output  1  block can accept a word this cycle.
- accum_i  input  1  sampled with the word. 1 adds the result to total_o; 0 replaces total_o with the result.
- clear_i  input  1  synchronous clear of total_o and sat_o.
- count_o  output  $clog2(WORDLEN+1)  set-bit count of the last completed word.
- total_o  output  ACCLEN  running total.
- valid_o  output  1  one-cycle strobe: count_o and total_o were just updated.
- sat_o  output  1  sticky flag: total_o has saturated.

## Operation
- Definitions: NCH = WORDLEN/CHUNK. The handshake fires when valid_i && ready_o.
- FSM states:
  - IDLE: ready_o=1.
    - On handshake: latch word_i into a shift register, latch accum_i, clear the partial sum, chunk index := 0, go to COUNT.
  - COUNT: ready_o=0.
    - Each cycle: partial += popcount(word_sr[CHUNK-1:0]), shift word_sr right by CHUNK, chunk index += 1.
    - After processing chunk NCH-1: load count_o with the final sum (partial plus the last chunk), update total_o and sat_o, go to DONE.
  - DONE: valid_o=1, ready_o=1.
    - On handshake: behave exactly as in IDLE and go to COUNT (back-to-back words).
    - Otherwise: go to IDLE.
- Total update at completion, with c = final count:
  - accum=0: total_o := c (zero-extended), sat_o := 0.
  - accum=1, total_o + c ≤ 2^ACCLEN−1: total_o := total_o + c; sat_o is unchanged.
  - accum=1, total_o + c > 2^ACCLEN−1: total_o := 2^ACCLEN−1, sat_o := 1.
  - The sum is computed ACCLEN+1 bits wide, so the overflow is never lost.
- clear_i:
  - Zeroes total_o and sat_o in any state.
  - Does not abort a count in progress and does not affect count_o.
  - If asserted in the completion cycle, the clear applies first, so the result is total_o := c and sat_o := 0 regardless of accum.
- count_o, total_o and sat_o hold their values between completions.
- word_i changes after the handshake have no effect on the result.
- valid_i is ignored while ready_o=0; no word is dropped or duplicated.
- CHUNK = WORDLEN degenerates to NCH = 1: a single COUNT cycle.

## Timing
- Reset (rst_i=1 at an edge) puts the FSM in IDLE and sets:
  - ready_o=1 (combinational from state)
  - valid_o=0, count_o=0, total_o=0, sat_o=0
  - the partial sum and chunk index to 0
- Reset mid-COUNT discards the word with no valid_o; reset overrides clear_i and the handshake.
- Latency: word accepted at edge E; COUNT occupies cycles E+1..E+NCH; valid_o is high in the cycle after edge E+NCH, i.e. NCH+1 edges after acceptance.
- Throughput, back-to-back via DONE: one word per NCH+1 cycles.
- ready_o and valid_o are decoded from state only, with no combinational path from valid_i.
- valid_o is never high for two consecutive cycles.

## Test plan
- Reset and idle: assert rst_i for 2 cycles, then release. Required: ready_o=1, valid_o=0, count_o=0, total_o=0, sat_o=0 and held.
- Single word, defaults: word_i=32'hF0F0_0001, accum_i=0. Required: valid_o one cycle, 5 edges after acceptance; count_o=9, total_o=9.
- Back-to-back accumulate: 32'hFFFF_FFFF, then 32'h0000_00FF, both accum_i=1, valid_i held high, and the first word uses accum_i=0. Required: second acceptance in DONE; second valid_o 5 cycles after the first; count_o=32 then 8; total_o=32 then 40.
- Saturation (ACCLEN=6): three words of 32'hFFFF_FFFF with accum_i=1, first word accum_i=0. Required: total_o=32, then 63 with sat_o=1, then 63 with sat_o=1.
- Clear at completion: pulse clear_i in the completion cycle of a word with count 4 while total_o=20 and accum_i=1. Required: total_o=4, sat_o=0.
- Reset mid-count: assert rst_i in the second COUNT cycle. Required: no valid_o, all outputs at reset values, and the next word counts correctly (32'h8000_0000 gives 1).
